// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: grants one operation at a time,
// latches it, captures the result and holds it until taken. Define ALU_ARB_ROUND_ROBIN_EN for alternating grants.
module alu_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req0_sel,
  input  logic [2:0]   req1_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_err,
  output logic         busy,
  output logic [7:0]   done_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] op_a, op_b;
  logic [2:0]   op_sel;
  logic         op_id;
  logic         pick1;
  logic         grant;

  function automatic logic sel_illegal(input logic [2:0] sel);
    return sel > 3'd4;
  endfunction

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // last_id resets to 1 so that requester 0 wins the first contention
  logic last_id;
  assign pick1 = req1_valid && (!req0_valid || !last_id);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_id <= 1'b1;
    else if (grant) last_id <= pick1;
  end
`else
  assign pick1 = req1_valid && !req0_valid;
`endif

  assign grant     = (state == IDLE) && (req0_valid || req1_valid);
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_sel   = op_sel;
  assign rsp_id    = op_id;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready = rst_n && !pick1;
          req1_ready = rst_n && pick1;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant stage: latch the winning operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= 3'd0;
      op_id  <= 1'b0;
    end else if (grant) begin
      op_a   <= pick1 ? req1_a   : req0_a;
      op_b   <= pick1 ? req1_b   : req0_b;
      op_sel <= pick1 ? req1_sel : req0_sel;
      op_id  <= pick1;
    end
  end

  // Execute stage: capture the ALU result, or flag an illegal opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_err    <= sel_illegal(op_sel);
      rsp_result <= sel_illegal(op_sel) ? '0 : alu_result;
    end
  end

  // Response stage: count completed handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          done_count <= 8'd0;
    else if (state == RESP && rsp_ready) done_count <= done_count + 8'd1;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, default 4, operand and result width; matches the shared ALU.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  W each  operands.
REQ-007 req0_sel, req1_sel  input  3 each  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101-111 illegal.
REQ-008 alu_a, alu_b  output  W each  operands driven to the shared ALU.
REQ-009 alu_sel  output  3  opcode driven to the shared ALU.
REQ-010 alu_result  input  W  combinational result returned by the shared ALU.
REQ-011 rsp_valid  output  1  a response is held.
REQ-012 rsp_ready  input  1  the consumer takes the response.
REQ-013 rsp_id  output  1  index of the requester that issued the operation.
REQ-014 rsp_result  output  W  captured ALU result.
REQ-015 rsp_err  output  1  opcode was illegal.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done_count  output  8  number of completed responses, wrapping.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-019 IDLE, no valid: remain in IDLE; both readys 0.
REQ-020 IDLE, any valid: grant one requester; its ready=1 combinationally in that cycle only; on the edge latch a/b/sel/id; go to EXEC.
REQ-021 Both valid: with ALU_ARB_ROUND_ROBIN_EN, grant the requester not granted last; otherwise grant requester 0.
REQ-022 A non-granted requester SHALL see ready=0; it holds valid and operands until granted.
REQ-023 alu_a, alu_b, alu_sel SHALL be driven from the latched operand registers in all states.
REQ-024 EXEC: on the edge capture alu_result into rsp_result (legal sel), or load 0 with rsp_err=1 (illegal sel); go to RESP.
REQ-025 RESP: rsp_valid=1; rsp_result, rsp_id and rsp_err are held stable until the handshake.
REQ-026 RESP with rsp_ready=1: on the edge drop rsp_valid, increment done_count (255 wraps to 0), go to IDLE.
REQ-027 RESP with rsp_ready=0: remain in RESP indefinitely; no new request is accepted.
REQ-028 Latency: grant in cycle k; rsp_valid=1 from cycle k+2; minimum spacing between grants is 3 cycles.
REQ-029 W-bit arithmetic wraps modulo 2^W inside the ALU; the block adds no carry or overflow flag.
REQ-030 rsp_ready while rsp_valid=0 SHALL be ignored.

Reset
REQ-031 rst_n low SHALL force asynchronously: state IDLE; operand registers, alu_a, alu_b, alu_sel, rsp_result and done_count to 0; rsp_valid, rsp_err, rsp_id, busy and both readys to 0; round-robin pointer so that requester 0 wins the next contention.
REQ-032 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced after reset is released.
REQ-033 The first grant is possible in the first cycle after rst_n rises.

Configuration
REQ-034 Macro ALU_ARB_ROUND_ROBIN_EN defined: a one-bit last-grant pointer, updated on each grant, alternates winners under contention.
REQ-035 ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins; the pointer register is not built.

Verification
REQ-036 Single op: req0 a=0011 b=0001 sel=000 -> req0_ready in cycle 0; cycle 2 rsp_valid=1, rsp_result=0100, rsp_id=0, rsp_err=0.
REQ-037 All opcodes: a=0011 b=0001 with sel 001/010/011/100 -> results 0010/0001/0011/0010; wrap case a=1111 b=0001 sel=000 -> 0000.
REQ-038 Contention: both valid continuously, rsp_ready=1 -> with the macro, rsp_id sequence 0,1,0,1; without it, 0,0,0,0.
REQ-039 Illegal op: sel=101 -> rsp_err=1, rsp_result=0000; done_count increments.
REQ-040 Backpressure and reset: rsp_ready=0 for 5 cycles -> rsp outputs held and no ready; assert rst_n mid-RESP -> all outputs 0 and state IDLE; 256 completions -> done_count returns to 0.
